// File: rtl/dsp_sequencer.sv
// Sequencing controller for the 4-tap averaging filter: one shift pulse per
// accepted sample, result capture one cycle later, tap flush, sample counter.
module dsp_sequencer #(
  parameter int          TAPS       = 4,
  parameter logic [4:0]  SHIFT_CODE = 5'b00001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic [4:0]  dsp_control,
  output logic [31:0] dsp_sample,
  input  logic [31:0] dsp_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] sample_count
);

  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, OUTPUT, FLUSH} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       flush_pend;
  logic       load, go_flush, done;

  assign in_ready = reset_n && (state == IDLE) && !flush_pend && !flush_req;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    dsp_control = '0;
    flush_busy  = 1'b0;
    load        = 1'b0;
    go_flush    = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // flush wins over a simultaneous sample
        if (flush_pend || flush_req) begin
          state_nx = FLUSH;
          cnt_nx   = 4'(TAPS);
          go_flush = 1'b1;
        end else if (in_valid) begin
          state_nx = SHIFT;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        dsp_control = SHIFT_CODE;
        state_nx    = CAPTURE;
      end
      CAPTURE: state_nx = OUTPUT;
      OUTPUT: begin
        if (out_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        dsp_control = SHIFT_CODE;
        flush_busy  = 1'b1;
        cnt_nx      = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      flush_pend   <= 1'b0;
      dsp_sample   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      sample_count <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      flush_pend <= go_flush ? 1'b0 : (flush_pend | flush_req);
      // sample bus is zeroed for the whole flush by clearing it on entry
      if (load)          dsp_sample <= in_data;
      else if (go_flush) dsp_sample <= '0;
      if (state == CAPTURE) begin
        out_data  <= dsp_result;
        out_valid <= 1'b1;
      end
      if (done) begin
        out_valid    <= 1'b0;
        sample_count <= sample_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer with a behavioural 4-tap averaging filter.
module tb_dsp_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        flush_req, flush_busy;
  logic [4:0]  dsp_control;
  logic [31:0] dsp_sample, dsp_result;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [15:0] sample_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dsp_sequencer #(.TAPS(4), .SHIFT_CODE(5'b00001)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .dsp_control(dsp_control), .dsp_sample(dsp_sample), .dsp_result(dsp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sample_count(sample_count)
  );

  // filter model: shares the reset net, shifts on SHIFT_CODE, sum of taps / 4
  logic [3:0][31:0]  taps;
  logic signed [33:0] fsum;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) taps <= '0;
    else if (dsp_control == 5'b00001) taps <= {taps[2:0], dsp_sample};
  end
  always_comb begin
    fsum = '0;
    for (int i = 0; i < 4; i++) fsum = fsum + $signed({{2{taps[i][31]}}, taps[i]});
    dsp_result = 32'(fsum >>> 2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush_req = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // drive a sample and wait (bounded) for the input handshake edge
  task automatic accept(input logic [31:0] d, input string tag);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // full sample with latency check; with out_ready=1 also checks the handshake
  task automatic run_sample(input logic [31:0] d, input logic [31:0] exp, input string tag);
    accept(d, tag);
    @(posedge clk); #1;
    chk({tag, "_valid_t1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_t2"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush_req = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_control", 32'(dsp_control), 32'd0);
    chk("rst_sample",  dsp_sample, 32'd0);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_data",    out_data, 32'd0);
    chk("rst_busy",    32'(flush_busy), 32'd0);
    chk("rst_count",   32'(sample_count), 32'd0);
    chk("rst_ready",   32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // running average of a ramp
    run_sample(32'd400,  32'd100,  "avg0");
    run_sample(32'd800,  32'd300,  "avg1");
    run_sample(32'd1200, 32'd600,  "avg2");
    run_sample(32'd1600, 32'd1000, "avg3");
    chk("avg_count", 32'(sample_count), 32'd4);

    // negative sample, then stall downstream for 5 cycles
    do_reset();
    out_ready = 1'b0;
    run_sample(32'hFFFFFFFC, 32'hFFFFFFFF, "neg");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data",    out_data, 32'hFFFFFFFF);
      chk("stall_valid",   32'(out_valid), 32'd1);
      chk("stall_ready",   32'(in_ready), 32'd0);
      chk("stall_control", 32'(dsp_control), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_valid_clr", 32'(out_valid), 32'd0);
    chk("stall_count", 32'(sample_count), 32'd1);

    // flush colliding with a sample
    do_reset();
    for (int i = 0; i < 4; i++) run_sample(32'd400, 32'(100 * (i + 1)), "load");
    @(negedge clk);
    flush_req = 1'b1; in_valid = 1'b1; in_data = 32'd8;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_control", 32'(dsp_control), 32'd1);
      chk("flush_sample",  dsp_sample, 32'd0);
      chk("flush_busy",    32'(flush_busy), 32'd1);
    end
    @(negedge clk);
    chk("flush_end_control", 32'(dsp_control), 32'd0);
    chk("flush_end_busy",    32'(flush_busy), 32'd0);
    chk("flush_end_ready",   32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_flush_sample", dsp_sample, 32'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_flush_data", out_data, 32'd2);
    chk("flush_count", 32'(sample_count), 32'd4);
    @(posedge clk); #1;
    chk("post_flush_count", 32'(sample_count), 32'd5);

    // reset in the middle of SHIFT
    accept(32'd999, "mid");
    chk("mid_shift_control", 32'(dsp_control), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_control", 32'(dsp_control), 32'd0);
    chk("mid_rst_sample",  dsp_sample, 32'd0);
    chk("mid_rst_valid",   32'(out_valid), 32'd0);
    chk("mid_rst_data",    out_data, 32'd0);
    chk("mid_rst_busy",    32'(flush_busy), 32'd0);
    chk("mid_rst_count",   32'(sample_count), 32'd0);
    chk("mid_rst_ready",   32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_sample(32'd40, 32'd10, "after_rst");
    chk("after_rst_count", 32'(sample_count), 32'd1);

    // counter wrap: preload FFFF while idle, then one more sample
    @(negedge clk);
    force dut.sample_count = 16'hFFFF;
    @(negedge clk);
    release dut.sample_count;
    @(negedge clk);
    chk("wrap_preload", 32'(sample_count), 32'h0000FFFF);
    run_sample(32'd0, 32'd10, "wrap");
    chk("wrap_count", 32'(sample_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
